// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared constants for the round-robin stream multiplexer family.
//   DEF_N_CH / DEF_WIDTH : default channel count and data width.
//   lock_state_e         : packet-lock FSM encoding (ST_IDLE=0, ST_LOCKED=1).
//                          It is only used when STREAM_MUX_PKT_LOCK_EN is defined.
// -----------------------------------------------------------------------------
package stream_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. It grants the first set req bit,
// scanning upward from ptr+1 and wrapping modulo N_CH. The pointer register is
// owned by the caller.
// Ports:
//   req     [N_CH]  request vector
//   ptr     [SEL_W] index of the last winner (the scan starts after it)
//   en      1       grant enable; when low, no grant is issued
//   gnt     [N_CH]  one-hot grant, or zero
//   gnt_idx [SEL_W] index of the granted channel (0 when gnt_any=0)
//   gnt_any 1       a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter
  import stream_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // Rotating priority scan: candidates are visited in order ptr+1, ptr+2, ...,
  // ptr+N_CH. The first requesting candidate wins, and gnt_any masks out
  // every later candidate.
  always_comb begin : p_scan
    int  k;
    logic hit;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = 0;
    hit     = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      k       = (int'(ptr) + i) % N_CH;
      hit     = en & req[k] & ~gnt_any;
      gnt[k]  = hit;
      gnt_idx = hit ? SEL_W'(k) : gnt_idx;
      gnt_any = gnt_any | hit;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// N_CH-input, WIDTH-bit stream multiplexer. It uses valid/ready handshakes on
// every channel, round-robin arbitration and a registered output stage with
// 1-cycle latency and full throughput.
// Optional build macro: STREAM_MUX_PKT_LOCK_EN. When it is defined, a channel
// that transfers a beat with in_last=0 keeps the grant until its beat with
// in_last=1. When it is undefined, in_last is ignored and arbitration is
// done per word.
// Ports:
//   clk        system clock (rising edge)
//   rst        synchronous active-high reset
//   in_data    [N_CH*WIDTH] flattened data; channel k at [k*WIDTH +: WIDTH]
//   in_valid   [N_CH] per-channel valid
//   in_last    [N_CH] per-channel end-of-packet (only used with the macro)
//   in_ready   [N_CH] combinational per-channel ready, one-hot or zero
//   out_data   [WIDTH] registered selected data
//   out_valid  registered valid
//   out_sel    [SEL_W] channel that supplied out_data
//   out_ready  consumer ready
// -----------------------------------------------------------------------------
module stream_mux_rr
  import stream_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load;
  logic             w_en;
  logic [N_CH-1:0]  w_req;
  logic [N_CH-1:0]  w_gnt;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_gnt_any;
  logic [WIDTH-1:0] w_sel_data;

  // The output register can accept a word when it is empty or being drained.
  // Reset suppresses every grant so that in_ready stays zero during reset.
  assign w_load = ~r_out_valid | out_ready;
  assign w_en   = w_load & ~rst;

`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_state_e      r_state;
  logic [SEL_W-1:0] r_lock_ch;

  // While a packet is open, only the locked channel may compete.
  always_comb begin
    w_req = in_valid;
    if (r_state == ST_LOCKED) begin
      w_req = in_valid & ({{(N_CH-1){1'b0}}, 1'b1} << r_lock_ch);
    end else begin
      w_req = in_valid;
    end
  end
`else
  logic w_unused_last;

  assign w_req         = in_valid;
  assign w_unused_last = ^in_last;
`endif

  rr_arbiter #(
    .N_CH    (N_CH)
  ) u_arb (
    .req     (w_req),
    .ptr     (r_ptr),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  // A grant is issued only for a valid channel, so a grant is also a transfer.
  assign in_ready   = w_gnt;
  assign w_sel_data = in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];

  // Output stage, round-robin pointer and (optional) packet-lock FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= SEL_W'(N_CH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
      r_state     <= ST_IDLE;
      r_lock_ch   <= '0;
`endif
    end else begin
      if (w_gnt_any) begin
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_gnt_idx;
        r_out_valid <= 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        case (r_state)
          ST_IDLE: begin
            r_ptr <= w_gnt_idx;
            if (!in_last[w_gnt_idx]) begin
              r_state   <= ST_LOCKED;
              r_lock_ch <= w_gnt_idx;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_LOCKED: begin
            // The pointer stays frozen inside a packet and lands on the
            // locked channel once the packet closes.
            if (in_last[w_gnt_idx]) begin
              r_state <= ST_IDLE;
              r_ptr   <= r_lock_ch;
            end else begin
              r_state <= ST_LOCKED;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_ptr   <= w_gnt_idx;
          end
        endcase
`else
        r_ptr <= w_gnt_idx;
`endif
      end else if (out_ready) begin
        // Drain: data and sel keep their last values.
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
// Scoreboard bench for stream_mux_rr (N_CH=4, WIDTH=8). A reference model
// predicts the grant on each cycle. It checks in_ready and pushes the expected
// word. The word is compared while it sits on the output and is popped when
// the consumer accepts it.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [1:0]     out_sel;
  logic           out_ready;

  always #5 clk = ~clk;

  stream_mux_rr #(
    .N_CH      (N),
    .WIDTH     (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  typedef struct {
    int         sel;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   m_ov;
  int   m_ptr;
  bit   m_locked;
  int   m_lock_ch;
  int   m_last_g;
  int   beats1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int first_from(input logic [3:0] v, input int p);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (p + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_data_seq();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'hA0 + 8'(k);
  endtask

  // One clock cycle: check at the negedge, then advance the model at the posedge.
  task automatic step();
    logic [3:0] mreq;
    logic [3:0] exp_ready;
    int         g;
    bit         load;
    exp_t       e;
    @(negedge clk);
    mreq = in_valid;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (m_locked) mreq = in_valid & (4'b0001 << m_lock_ch);
`endif
    load      = !m_ov || out_ready;
    g         = (!rst && load) ? first_from(mreq, m_ptr) : -1;
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: out_valid with no expected word (t=%0t)", $time);
      end else begin
        check("out_data", out_data, q[0].data);
        check("out_sel", out_sel, q[0].sel);
        if (out_ready && !rst) void'(q.pop_front());
      end
    end
    m_last_g = g;
    if (rst) begin
      m_ov     = 1'b0;
      m_ptr    = N - 1;
      m_locked = 1'b0;
      q.delete();
    end else if (g >= 0) begin
      e.sel  = g;
      e.data = in_data[g*W +: W];
      q.push_back(e);
      m_ov = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (!m_locked) begin
        m_ptr = g;
        if (!in_last[g]) begin
          m_locked  = 1'b1;
          m_lock_ch = g;
        end
      end else if (in_last[g]) begin
        m_locked = 1'b0;
        m_ptr    = m_lock_ch;
      end
`else
      m_ptr = g;
`endif
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = '0;
    set_data_seq();
    m_ov      = 1'b0;
    m_ptr     = N - 1;
    m_locked  = 1'b0;
    m_lock_ch = 0;
    beats1    = 0;
    @(posedge clk);
    #1;

    // Reset held with every channel valid.
    repeat (2) step();
    check("rst_data", out_data, 32'h0);
    check("rst_sel", out_sel, 32'h0);

    // Rotation A0..A3, A0, A1.
    rst = 1'b0;
    repeat (6) step();

    // Backpressure while A1 sits on the output.
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    step();

    // Sparse requests: move the pointer to 3, then only ch2 is valid, so the scan wraps.
    in_valid = 4'b1000;
    step();
    in_valid = 4'b0100;
    in_data[2*W +: W] = 8'h5C;
    step();
    in_valid = 4'b0000;
    step();
    in_valid = 4'b1010;
    repeat (2) step();
    in_valid = 4'b0000;
    repeat (2) step();

    // Reset mid-stream.
    set_data_seq();
    in_valid = 4'b1111;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();

    // Three-beat packet on ch1 while ch0 and ch2 compete.
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 4'b0010;
    in_last  = 4'b1101;
    step();
    if (m_last_g == 1) beats1++;
    in_valid = 4'b0111;
    for (int c = 0; c < 8; c++) begin
      in_last[1] = (beats1 >= 2);
      step();
      if (m_last_g == 1) beats1++;
    end

    // Random traffic with backpressure and occasional reset.
    for (int c = 0; c < 300; c++) begin
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      step();
    end

    rst       = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit successor to the 2:1 select mux.
- Adds per-channel valid/ready handshakes, round-robin arbitration and a registered output stage.
- Sits between several producer streams and a single consumer in the datapath.
- Replaces hard-wired select logic wherever more than one source shares a sink.

Parameters:
- N_CH, 4: number of input channels; must be 2..16.
- WIDTH, 8: data width per channel in bits.
- SEL_W, $clog2(N_CH): width of the channel index. Derived localparam; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  N_CH*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_last  input  N_CH  per-channel end-of-packet flag. Used only when the optional feature is compiled in; ignored otherwise.
- in_ready  output  N_CH  per-channel ready. Combinational, one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer=N_CH-1 (so channel 0 wins first), lock state=IDLE.
- in_ready during reset: all zero while rst=1.
- Load enable: load = !out_valid | out_ready.
- Grant: when load=1 and any in_valid bit is set, grant the first valid channel scanning upward from pointer+1, modulo N_CH. Set in_ready[grant]=1; all other in_ready bits are 0.
- in_ready must never be asserted for a channel whose in_valid=0.
- Transfer: a transfer on channel k occurs when in_valid[k] & in_ready[k].
- On a transfer, next edge: out_data <= data of k, out_sel <= k, out_valid <= 1, pointer <= k.
- Drain with no new load: if out_valid & out_ready and no input is granted, out_valid <= 0. out_data and out_sel hold their values.
- Stall: out_valid=1 & out_ready=0 forces load=0. All in_ready=0; out_data, out_sel and out_valid hold.
- Latency and throughput: input-to-output latency is exactly 1 cycle. Sustained throughput is 1 word per cycle while out_ready=1.
- Fairness: with all channels valid continuously, grants rotate 0,1,..,N_CH-1,0,...
- No valid inputs: if no in_valid bit is set, the pointer does not move.
- Pointer wrap: the pointer wraps from N_CH-1 to 0.
- Reset mid-operation: the word held in the output register is discarded (out_valid=0 next cycle). Any lock is released.
- Input handshake rule: a producer must not drop valid or change data while valid=1 and ready=0. The block does not check this.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined: two-state FSM, IDLE and LOCKED.
  - IDLE to LOCKED on a transfer with in_last[k]=0; lock_ch <= k.
  - While LOCKED, only lock_ch may be granted; other valid channels wait. The pointer is not updated.
  - LOCKED to IDLE on a transfer from lock_ch with in_last=1; pointer <= lock_ch.
  - A transfer with in_last=1 from IDLE stays in IDLE (single-beat packet).
- Undefined: in_last is ignored, no FSM exists, and arbitration is per word as described above.
- The port list is identical in both builds.

Decomposition:
- Shared package (stream_pkg) holds:
  - the default WIDTH and N_CH constants;
  - the lock-state encoding constants (ST_IDLE=1'b0, ST_LOCKED=1'b1).
- One sub-module, rr_arbiter:
  - parameter N_CH;
  - inputs: req[N_CH], ptr[SEL_W], en;
  - outputs: gnt[N_CH] (one-hot), gnt_idx[SEL_W], gnt_any.
  - Purely combinational; the pointer register stays in stream_mux_rr.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0000 and out_valid=0 throughout. First grant after release is channel 0.
- Rotation: N_CH=4, all valid, out_ready=1, in_data ch k = 8'hA0+k -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; out_sel 0,1,2,3,0.
- Backpressure: out_ready=0 for 3 cycles while out_data=A1 -> out_data, out_valid and out_sel held; in_ready=0000. On release, next word is A2 one cycle later.
- Sparse requests: only ch2 valid (8'h5C), pointer=3 -> grant wraps to ch2; out_data=5C next cycle. Then ch1 and ch3 valid -> ch3 granted first.
- Reset mid-stream: assert rst with out_valid=1 -> out_valid=0 next cycle. Pointer reset so ch0 wins next.
- With STREAM_MUX_PKT_LOCK_EN: ch1 sends 3 beats (last on beat 3) while ch0 and ch2 are valid -> ch1 beats are contiguous and ch2 is granted next. Without the macro, the same stimulus interleaves ch1, ch2, ch0.
